// File: rtl/addr_gen_upd_rd.sv
// Read-address generator for the LSTM weight update: sweeps the W, U and b regions in order,
// holding each address for DELAY enabled cycles so the update datapath can consume it.
module addr_gen_upd_rd #(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_CELL   = 8,
  parameter int NUM_INPUT  = 53,
  parameter int DELAY      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [1:0]            o_sel,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [2:0] {IDLE, RD_W, RD_U, RD_B, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] W_LAST    = ADDR_WIDTH'(NUM_CELL * NUM_INPUT - 1);
  localparam logic [ADDR_WIDTH-1:0] U_LAST    = ADDR_WIDTH'(NUM_CELL * NUM_CELL - 1);
  localparam logic [ADDR_WIDTH-1:0] B_LAST    = ADDR_WIDTH'(NUM_CELL - 1);
  localparam logic [ADDR_WIDTH-1:0] HOLD_LAST = ADDR_WIDTH'(DELAY - 1);

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   hold_cnt, hold_cnt_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic [ADDR_WIDTH-1:0]   region_last;
  logic [1:0]              sel_n;
  logic                    valid_n, busy_n, done_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      o_addr   <= '0;
      o_sel    <= 2'd0;
      o_valid  <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_cnt_n;
      o_addr   <= addr_n;
      o_sel    <= sel_n;
      o_valid  <= valid_n;
      o_busy   <= busy_n;
      o_done   <= done_n;
    end
  end

  // Outputs are computed one cycle ahead so that every port comes straight from a flop.
  always_comb begin
    state_n     = state;
    hold_cnt_n  = hold_cnt;
    addr_n      = o_addr;
    sel_n       = o_sel;
    valid_n     = o_valid;
    busy_n      = o_busy;
    done_n      = o_done;
    region_last = W_LAST;

    case (state)
      RD_U:    region_last = U_LAST;
      RD_B:    region_last = B_LAST;
      default: region_last = W_LAST;
    endcase

    unique case (state)
      IDLE: begin
        hold_cnt_n = '0;
        addr_n     = '0;
        sel_n      = 2'd0;
        valid_n    = 1'b0;
        busy_n     = 1'b0;
        done_n     = 1'b0;
        if (start) begin
          state_n = RD_W;
          valid_n = 1'b1;
          busy_n  = 1'b1;
        end
      end

      RD_W, RD_U, RD_B: begin
        if (en) begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt_n = '0;
            if (o_addr == region_last) begin
              addr_n = '0;
              case (state)
                RD_W: begin
                  state_n = RD_U;
                  sel_n   = 2'd1;
                end
                RD_U: begin
                  state_n = RD_B;
                  sel_n   = 2'd2;
                end
                default: begin
                  state_n = DONE;
                  sel_n   = 2'd0;
                  valid_n = 1'b0;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                end
              endcase
            end else begin
              addr_n = o_addr + ADDR_WIDTH'(1);
            end
          end else begin
            hold_cnt_n = hold_cnt + ADDR_WIDTH'(1);
          end
        end
      end

      DONE: begin
        state_n    = IDLE;
        hold_cnt_n = '0;
        addr_n     = '0;
        sel_n      = 2'd0;
        valid_n    = 1'b0;
        busy_n     = 1'b0;
        done_n     = 1'b0;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_addr_gen_upd_rd.sv
// Randomized bench for addr_gen_upd_rd: three parameterisations checked against a
// sweep model built as a flat list of (region, address) pairs.
module tb_addr_gen_upd_rd;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start_v, en_v;

  logic [11:0] addr0, addr1, addr2;
  logic [1:0]  sel0, sel1, sel2;
  logic        valid0, valid1, valid2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;

  int          cur;
  logic [16:0] obs;
  int          tests_run = 0;
  int          tests_failed = 0;

  int dly [3] = '{2, 1, 7};
  int nc  [3] = '{2, 2, 8};
  int ni  [3] = '{3, 3, 53};

  always #5 clk = ~clk;

  addr_gen_upd_rd #(.ADDR_WIDTH(12), .NUM_CELL(2), .NUM_INPUT(3), .DELAY(2)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .en(en_v[0]),
    .o_addr(addr0), .o_sel(sel0), .o_valid(valid0), .o_busy(busy0), .o_done(done0));

  addr_gen_upd_rd #(.ADDR_WIDTH(12), .NUM_CELL(2), .NUM_INPUT(3), .DELAY(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .en(en_v[1]),
    .o_addr(addr1), .o_sel(sel1), .o_valid(valid1), .o_busy(busy1), .o_done(done1));

  addr_gen_upd_rd dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .en(en_v[2]),
    .o_addr(addr2), .o_sel(sel2), .o_valid(valid2), .o_busy(busy2), .o_done(done2));

  // Outputs of the instance under test, packed as {valid, busy, done, sel, addr}.
  always_comb begin
    case (cur)
      0:       obs = {valid0, busy0, done0, sel0, addr0};
      1:       obs = {valid1, busy1, done1, sel1, addr1};
      default: obs = {valid2, busy2, done2, sel2, addr2};
    endcase
  end

  function automatic logic [16:0] pk(input bit v, input bit b, input bit d,
                                     input int s, input int a);
    return {v, b, d, 2'(s), 12'(a)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s (dut%0d): got %0h, expected %0h", tag, cur, act, exp);
    end
  endtask

  // One sweep on instance 'cur'. mode 0: en held 1, else random en.
  // inject: random start pulses while busy and in DONE. abort_at: model step at which to reset.
  task automatic applyStimulus(input int mode, input bit inject, input int abort_at);
    int d, total, n, vcnt;
    bit fin;
    int ssel[$];
    int sadr[$];
    d = dly[cur];
    for (int a = 0; a < nc[cur] * ni[cur]; a++) begin ssel.push_back(0); sadr.push_back(a); end
    for (int a = 0; a < nc[cur] * nc[cur]; a++) begin ssel.push_back(1); sadr.push_back(a); end
    for (int a = 0; a < nc[cur]; a++)           begin ssel.push_back(2); sadr.push_back(a); end
    total = d * ssel.size();

    start_v[cur] = 1'b1;
    en_v[cur]    = 1'($urandom_range(0, 1));
    @(negedge clk);
    start_v[cur] = 1'b0;
    n = 0; vcnt = 0; fin = 1'b0;

    for (int c = 0; c < total * 4 + 20 && !fin; c++) begin
      if (n < total) begin
        checkOutput("sweep", 32'(obs), 32'(pk(1, 1, 0, ssel[n / d], sadr[n / d])));
        vcnt++;
        if (n == abort_at) begin
          rst = 1'b0; en_v[cur] = 1'b1; start_v[cur] = 1'b1;
          @(negedge clk);
          checkOutput("rst_mid", 32'(obs), 32'd0);
          rst = 1'b1; start_v[cur] = 1'b0;
          @(negedge clk);
          checkOutput("rst_idle", 32'(obs), 32'd0);
          return;
        end
        en_v[cur]    = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        start_v[cur] = inject ? 1'($urandom_range(0, 1)) : 1'b0;
        if (en_v[cur]) n++;
      end else begin
        checkOutput("done", 32'(obs), 32'(pk(0, 0, 1, 0, 0)));
        fin = 1'b1;
        en_v[cur]    = 1'($urandom_range(0, 1));
        start_v[cur] = inject;
      end
      @(negedge clk);
    end

    if (!fin) checkOutput("timeout", 32'd0, 32'd1);
    if (mode == 0 && fin)
      checkOutput("valid_cycles", 32'(vcnt), 32'(d * nc[cur] * (ni[cur] + nc[cur] + 1)));
    start_v[cur] = 1'b0;
    en_v[cur]    = 1'b0;
    checkOutput("idle_after", 32'(obs), 32'd0);
    @(negedge clk);
    checkOutput("idle_hold", 32'(obs), 32'd0);
  endtask

  initial begin
    cur     = 0;
    rst     = 1'b0;
    start_v = 3'b111;
    en_v    = 3'b111;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cur = i;
      #1;
      checkOutput("reset", 32'(obs), 32'd0);
    end
    rst     = 1'b1;
    start_v = 3'b000;
    en_v    = 3'b000;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cur = i;
      #1;
      checkOutput("idle_no_start", 32'(obs), 32'd0);
    end

    cur = 0;
    applyStimulus(0, 1'b0, -1);
    applyStimulus(1, 1'b0, -1);
    applyStimulus(1, 1'b1, -1);
    applyStimulus(0, 1'b1, -1);
    applyStimulus(0, 1'b0, 16);
    applyStimulus(0, 1'b0, -1);
    applyStimulus(1, 1'b1, 15);
    applyStimulus(1, 1'b1, -1);

    cur = 1;
    applyStimulus(0, 1'b0, -1);
    applyStimulus(1, 1'b1, -1);

    cur = 2;
    applyStimulus(0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
